wb_mem_arbiter: RTL and testbench

WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

---
 rtl/wb_mem_arbiter_if.sv | 31 +++
 rtl/wb_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/wb_mem_arbiter_if.sv
// Wishbone B4 bus bundle shared by both masters and the memory-side slave port.
// The master modport drives requests; the slave modport returns terminations and read data.
interface wb_mem_arbiter_if #(
    parameter int dw = 32,
    parameter int aw = 32
);

    logic [aw-1:0]   adr;
    logic [dw-1:0]   dat_w;
    logic [dw/8-1:0] sel;
    logic            we;
    logic            cyc;
    logic            stb;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic            ack;
    logic            err;
    logic            rty;
    logic [dw-1:0]   dat_r;

    modport master (
        output adr, dat_w, sel, we, cyc, stb, cti, bte,
        input  ack, err, rty, dat_r
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb, cti, bte,
        output ack, err, rty, dat_r
    );

endinterface

// File: rtl/wb_mem_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single memory slave.
// Optional bus watchdog: define WB_MEM_ARB_TIMEOUT_EN to abort cycles the slave never terminates.
module wb_mem_arbiter #(
    parameter int dw      = 32,
    parameter int aw      = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    wb_mem_arbiter_if.slave   wbm0,
    wb_mem_arbiter_if.slave   wbm1,
    wb_mem_arbiter_if.master  wbs
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e state;
    logic   last_gnt;     // master served most recently; the other one wins a tie
    logic   timeout_hit;
    logic   slv_stb;
    logic   slv_term;

    if ((dw % 8) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("wb_mem_arbiter: dw must be a multiple of 8 and TIMEOUT at least 1");
    end

    assign slv_term = wbs.ack | wbs.err | wbs.rty;

`ifdef WB_MEM_ARB_TIMEOUT_EN
    localparam int cw = $clog2(TIMEOUT + 1);

    logic [cw-1:0] wdog_cnt;

    // Counts strobed cycles without a termination; idle time keeps it cleared so
    // every grant starts from zero.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wdog_cnt <= '0;
        end else if (state == IDLE || slv_term) begin
            wdog_cnt <= '0;
        end else if (slv_stb) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state != IDLE) && (wdog_cnt == cw'(TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: non-blocking assignments keep every register update in this block
    // order-independent; the asynchronous reset branch clears state and points
    // last_gnt at master 1 so master 0 wins the first contended request.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (wbm0.cyc && wbm1.cyc) begin
                        state <= last_gnt ? GNT0 : GNT1;
                    end else if (wbm0.cyc) begin
                        state <= GNT0;
                    end else if (wbm1.cyc) begin
                        state <= GNT1;
                    end
                end
                GNT0: begin
                    if (!wbm0.cyc || timeout_hit) begin
                        state    <= IDLE;
                        last_gnt <= 1'b0;
                    end
                end
                GNT1: begin
                    if (!wbm1.cyc || timeout_hit) begin
                        state    <= IDLE;
                        last_gnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus routing is purely a function of the current owner, so an ack that
    // arrives in the cycle the owner drops cyc still reaches that owner.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        wbs.adr    = '0;
        wbs.dat_w  = '0;
        wbs.sel    = '0;
        wbs.we     = 1'b0;
        wbs.cyc    = 1'b0;
        wbs.stb    = 1'b0;
        wbs.cti    = '0;
        wbs.bte    = '0;
        wbm0.ack   = 1'b0;
        wbm0.err   = 1'b0;
        wbm0.rty   = 1'b0;
        wbm0.dat_r = '0;
        wbm1.ack   = 1'b0;
        wbm1.err   = 1'b0;
        wbm1.rty   = 1'b0;
        wbm1.dat_r = '0;
        slv_stb    = 1'b0;

        case (state)
            GNT0: begin
                wbs.adr    = wbm0.adr;
                wbs.dat_w  = wbm0.dat_w;
                wbs.sel    = wbm0.sel;
                wbs.we     = wbm0.we;
                wbs.cyc    = wbm0.cyc & ~timeout_hit;
                slv_stb    = wbm0.stb & ~timeout_hit;
                wbs.stb    = slv_stb;
                wbs.cti    = wbm0.cti;
                wbs.bte    = wbm0.bte;
                wbm0.ack   = wbs.ack;
                wbm0.err   = wbs.err | timeout_hit;
                wbm0.rty   = wbs.rty;
                wbm0.dat_r = wbs.dat_r;
            end
            GNT1: begin
                wbs.adr    = wbm1.adr;
                wbs.dat_w  = wbm1.dat_w;
                wbs.sel    = wbm1.sel;
                wbs.we     = wbm1.we;
                wbs.cyc    = wbm1.cyc & ~timeout_hit;
                slv_stb    = wbm1.stb & ~timeout_hit;
                wbs.stb    = slv_stb;
                wbs.cti    = wbm1.cti;
                wbs.bte    = wbm1.bte;
                wbm1.ack   = wbs.ack;
                wbm1.err   = wbs.err | timeout_hit;
                wbm1.rty   = wbs.rty;
                wbm1.dat_r = wbs.dat_r;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: single transfer, round-robin tie, burst hold,
// mid-burst reset and watchdog (or indefinite hold when the watchdog is compiled out).
module tb_wb_mem_arbiter;

    localparam int dw = 32;
    localparam int aw = 32;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    wb_mem_arbiter_if #(.dw(dw), .aw(aw)) m0 ();
    wb_mem_arbiter_if #(.dw(dw), .aw(aw)) m1 ();
    wb_mem_arbiter_if #(.dw(dw), .aw(aw)) sl ();

    wb_mem_arbiter #(.dw(dw), .aw(aw), .TIMEOUT(8)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbm0      (m0),
        .wbm1      (m1),
        .wbs       (sl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic err_seen;
        logic drop_seen;

        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        m0.adr = '0; m0.dat_w = '0; m0.sel = '0; m0.we = 1'b0;
        m0.cyc = 1'b0; m0.stb = 1'b0; m0.cti = '0; m0.bte = '0;
        m1.adr = '0; m1.dat_w = '0; m1.sel = '0; m1.we = 1'b0;
        m1.cyc = 1'b0; m1.stb = 1'b0; m1.cti = '0; m1.bte = '0;
        sl.ack = 1'b0; sl.err = 1'b0; sl.rty = 1'b0; sl.dat_r = 32'hCAFE_F00D;

        // Reset state
        tick();
        #1;
        check("rst_cyc",     64'(sl.cyc), 64'd0);
        check("rst_stb",     64'(sl.stb), 64'd0);
        check("rst_m0_dat",  64'(m0.dat_r), 64'd0);
        rst_n = 1'b1;

        // Single write from master 0
        tick();
        m0.adr = 32'h10; m0.dat_w = 32'hDEAD_BEEF; m0.sel = 4'hF; m0.we = 1'b1;
        m0.cyc = 1'b1; m0.stb = 1'b1;
        #1;
        check("wr_lat_cyc",  64'(sl.cyc), 64'd0);
        tick();
        #1;
        check("wr_cyc",      64'(sl.cyc), 64'd1);
        check("wr_adr",      64'(sl.adr), 64'h10);
        check("wr_dat",      64'(sl.dat_w), 64'hDEAD_BEEF);
        check("wr_sel",      64'(sl.sel), 64'hF);
        check("wr_we",       64'(sl.we), 64'd1);
        sl.ack = 1'b1;
        #1;
        check("wr_m0_ack",   64'(m0.ack), 64'd1);
        check("wr_m1_ack",   64'(m1.ack), 64'd0);
        tick();
        m0.cyc = 1'b0; m0.stb = 1'b0; m0.we = 1'b0; sl.ack = 1'b0;
        tick();
        #1;
        check("wr_idle",     64'(sl.cyc), 64'd0);

        // Fresh reset, then both masters request on the same edge
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m0.adr = 32'h10; m0.cyc = 1'b1; m0.stb = 1'b1;
        m1.adr = 32'h20; m1.cyc = 1'b1; m1.stb = 1'b1;
        tick();
        #1;
        check("tie_adr",     64'(sl.adr), 64'h10);
        check("tie_m0_dat",  64'(m0.dat_r), 64'hCAFE_F00D);
        check("tie_m1_dat",  64'(m1.dat_r), 64'd0);
        // Owner drops cyc in the same cycle its ack arrives
        sl.ack = 1'b1; m0.cyc = 1'b0; m0.stb = 1'b0;
        #1;
        check("drop_m0_ack", 64'(m0.ack), 64'd1);
        check("drop_m1_ack", 64'(m1.ack), 64'd0);
        tick();
        sl.ack = 1'b0;
        #1;
        check("gap_cyc",     64'(sl.cyc), 64'd0);
        tick();
        #1;
        check("m1_cyc",      64'(sl.cyc), 64'd1);
        check("m1_adr",      64'(sl.adr), 64'h20);

        // Master 1 incrementing burst while master 0 keeps requesting
        m0.cyc = 1'b1; m0.stb = 1'b1;
        m1.bte = 2'b00;
        for (int i = 0; i < 4; i++) begin
            m1.adr = 32'h20 + 32'(4 * i);
            m1.cti = (i == 3) ? 3'b111 : 3'b010;
            sl.ack = 1'b1;
            #1;
            check("bst_adr",    64'(sl.adr), 64'(32'h20 + 32'(4 * i)));
            check("bst_cti",    64'(sl.cti), (i == 3) ? 64'd7 : 64'd2);
            check("bst_m1_ack", 64'(m1.ack), 64'd1);
            check("bst_m0_ack", 64'(m0.ack), 64'd0);
            tick();
        end
        m1.cyc = 1'b0; m1.stb = 1'b0; m1.cti = '0; sl.ack = 1'b0;
        tick();
        #1;
        check("bst_gap",     64'(sl.cyc), 64'd0);
        tick();
        #1;
        check("bst_m0_gnt",  64'(sl.adr), 64'h10);

        // Reset asserted in the middle of a master 0 burst with master 1 waiting
        m0.cti = 3'b010; m1.cyc = 1'b1; m1.stb = 1'b1; sl.ack = 1'b1;
        #1;
        check("pre_rst_ack", 64'(m0.ack), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cyc", 64'(sl.cyc), 64'd0);
        check("mid_rst_adr", 64'(sl.adr), 64'd0);
        check("mid_rst_ack", 64'(m0.ack), 64'd0);
        check("mid_rst_dat", 64'(m0.dat_r), 64'd0);
        sl.ack = 1'b0;
        tick();
        rst_n = 1'b1;
        m0.cti = '0;
        tick();
        #1;
        check("post_rst_adr", 64'(sl.adr), 64'h10);
        m0.cyc = 1'b0; m0.stb = 1'b0; m1.cyc = 1'b0; m1.stb = 1'b0;
        tick();
        tick();
        #1;
        check("post_rst_idle", 64'(sl.cyc), 64'd0);

        // Slave never responds
        m0.cyc = 1'b1; m0.stb = 1'b1;
        tick();
`ifdef WB_MEM_ARB_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            #1;
            check("wd_stb",  64'(sl.stb), 64'd1);
            check("wd_err0", 64'(m0.err), 64'd0);
            tick();
        end
        #1;
        check("wd_err",      64'(m0.err), 64'd1);
        check("wd_cyc_drop", 64'(sl.cyc), 64'd0);
        check("wd_stb_drop", 64'(sl.stb), 64'd0);
        m0.cyc = 1'b0; m0.stb = 1'b0;
        tick();
        #1;
        check("wd_err_pulse", 64'(m0.err), 64'd0);
        check("wd_idle",      64'(sl.cyc), 64'd0);
`else
        err_seen  = 1'b0;
        drop_seen = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            #1;
            err_seen  = err_seen | m0.err;
            drop_seen = drop_seen | ~sl.cyc | ~sl.stb;
            tick();
        end
        check("hold_err",  64'(err_seen), 64'd0);
        check("hold_drop", 64'(drop_seen), 64'd0);
        check("hold_cyc",  64'(sl.cyc), 64'd1);
        m0.cyc = 1'b0; m0.stb = 1'b0;
        tick();
        tick();
        #1;
        check("hold_release", 64'(sl.cyc), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
